// File: rtl/framebuffer_streamer_pkg.sv
// Shared definitions for the OLED framebuffer reader and writer: panel geometry,
// FSM state encodings and the prefetch occupancy helper.
package framebuffer_streamer_pkg;

    localparam int OLED_WIDTH     = 128;
    localparam int OLED_PAGES     = 8;
    localparam int FB_FRAME_BYTES = OLED_WIDTH * OLED_PAGES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_e;

    // Bytes held or owed to the stream once this cycle's handshake has retired one.
    function automatic logic [1:0] pipe_occupancy(input logic [1:0] occ,
                                                  input logic       hs,
                                                  input logic       in_flight);
        pipe_occupancy = occ + {1'b0, in_flight} - {1'b0, hs};
    endfunction

endpackage

// File: rtl/framebuffer_streamer_skid.sv
// fb_skid_buffer: two-entry valid/ready buffer (output register plus one skid entry)
// that absorbs the BRAM read in flight when the sink stalls.
module fb_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [1:0]            occupancy
);

    logic                  out_valid_r, out_valid_nx_s;
    logic [DATA_WIDTH-1:0] out_data_r,  out_data_nx_s;
    logic                  out_last_r,  out_last_nx_s;
    logic                  skid_valid_r, skid_valid_nx_s;
    logic [DATA_WIDTH-1:0] skid_data_r,  skid_data_nx_s;
    logic                  skid_last_r,  skid_last_nx_s;
    logic                  hs_s;

    assign hs_s = out_valid_r & out_ready;

    // Next-state for the output register and skid entry; the skid always drains first
    always_comb begin
        out_valid_nx_s  = out_valid_r;
        out_data_nx_s   = out_data_r;
        out_last_nx_s   = out_last_r;
        skid_valid_nx_s = skid_valid_r;
        skid_data_nx_s  = skid_data_r;
        skid_last_nx_s  = skid_last_r;
        if (flush) begin
            out_valid_nx_s  = 1'b0;
            skid_valid_nx_s = 1'b0;
        end else if (!out_valid_r || hs_s) begin
            if (skid_valid_r) begin
                out_valid_nx_s  = 1'b1;
                out_data_nx_s   = skid_data_r;
                out_last_nx_s   = skid_last_r;
                skid_valid_nx_s = in_valid;
                skid_data_nx_s  = in_valid ? in_data : skid_data_r;
                skid_last_nx_s  = in_valid ? in_last : skid_last_r;
            end else begin
                out_valid_nx_s  = in_valid;
                out_data_nx_s   = in_valid ? in_data : out_data_r;
                out_last_nx_s   = in_valid ? in_last : out_last_r;
            end
        end else begin
            skid_valid_nx_s = skid_valid_r | in_valid;
            skid_data_nx_s  = in_valid ? in_data : skid_data_r;
            skid_last_nx_s  = in_valid ? in_last : skid_last_r;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_WIDTH{1'b0}};
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_WIDTH{1'b0}};
            skid_last_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nx_s;
            out_data_r   <= out_data_nx_s;
            out_last_r   <= out_last_nx_s;
            skid_valid_r <= skid_valid_nx_s;
            skid_data_r  <= skid_data_nx_s;
            skid_last_r  <= skid_last_nx_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign occupancy = {1'b0, out_valid_r} + {1'b0, skid_valid_r};

endmodule

// File: rtl/framebuffer_streamer.sv
// Scans one framebuffer frame out of BRAM port B as a valid/ready byte stream.
// Optional FB_STREAMER_DOUBLE_BUFFER_EN adds swap_req/disp_bank bank flipping.
module framebuffer_streamer
    import framebuffer_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_BYTES = 1024,
    parameter int BASE_ADDR   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last
`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
    ,
    input  logic                  swap_req,
    output logic                  disp_bank
`endif
);

    localparam int                    CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BANK_STRIDE = ADDR_WIDTH'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO   = {ADDR_WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]      LAST_IDX    = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0]      FRAME_CNT   = CNT_W'(FRAME_BYTES);

    fb_state_e             state_r, state_nx_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
    logic                  in_flight_r, in_flight_nx_s;
    logic                  in_flight_last_r, in_flight_last_nx_s;
    logic                  busy_r, busy_nx_s;
    logic                  done_r, done_nx_s;
    logic [1:0]            occ_s;
    logic                  hs_s, flush_s, issue_s, start_acc_s;
    logic                  bank_s, swap_pend_s;
    logic [ADDR_WIDTH-1:0] base_cur_s, base_next_s;

    assign hs_s        = tx_valid & tx_ready;
    assign start_acc_s = (state_r == ST_IDLE) && start && !abort;
    assign flush_s     = abort && ((state_r == ST_RUN) || (state_r == ST_FLUSH));
    assign issue_s     = (state_r == ST_RUN) && !abort && (cnt_r != FRAME_CNT) &&
                         (pipe_occupancy(occ_s, hs_s, in_flight_r) < 2'd2);

`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
    logic bank_r, swap_pend_r;

    // Display bank and pending swap; the bank flips only when a new frame is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r      <= 1'b0;
            swap_pend_r <= 1'b0;
        end else if (start_acc_s) begin
            bank_r      <= bank_r ^ swap_pend_r;
            swap_pend_r <= swap_req;
        end else begin
            swap_pend_r <= swap_pend_r | swap_req;
        end
    end

    assign bank_s      = bank_r;
    assign swap_pend_s = swap_pend_r;
    assign disp_bank   = bank_r;
`else
    assign bank_s      = 1'b0;
    assign swap_pend_s = 1'b0;
`endif

    assign base_cur_s  = BASE_A + (bank_s ? BANK_STRIDE : ADDR_ZERO);
    assign base_next_s = BASE_A + ((bank_s ^ swap_pend_s) ? BANK_STRIDE : ADDR_ZERO);

    // Frame FSM with read address/issue counter and status next-state
    always_comb begin
        state_nx_s          = state_r;
        addr_nx_s           = addr_r;
        cnt_nx_s            = cnt_r;
        in_flight_nx_s      = issue_s;
        in_flight_last_nx_s = issue_s && (cnt_r == LAST_IDX);
        busy_nx_s           = busy_r;
        done_nx_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = {CNT_W{1'b0}};
                if (start_acc_s) begin
                    state_nx_s = ST_RUN;
                    addr_nx_s  = base_next_s;
                    busy_nx_s  = 1'b1;
                end else begin
                    addr_nx_s  = base_cur_s;
                    busy_nx_s  = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                    addr_nx_s  = base_cur_s;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    busy_nx_s  = 1'b0;
                end else if (issue_s) begin
                    addr_nx_s  = addr_r + ADDR_WIDTH'(1);
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                    state_nx_s = (cnt_r == LAST_IDX) ? ST_FLUSH : ST_RUN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                    addr_nx_s  = base_cur_s;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    busy_nx_s  = 1'b0;
                end else if (hs_s && tx_last) begin
                    state_nx_s = ST_DONE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
                addr_nx_s  = base_cur_s;
                cnt_nx_s   = {CNT_W{1'b0}};
                busy_nx_s  = 1'b0;
            end
            default: begin
                state_nx_s = ST_IDLE;
                addr_nx_s  = base_cur_s;
                cnt_nx_s   = {CNT_W{1'b0}};
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // FSM, counter and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            addr_r           <= BASE_A;
            cnt_r            <= {CNT_W{1'b0}};
            in_flight_r      <= 1'b0;
            in_flight_last_r <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            addr_r           <= addr_nx_s;
            cnt_r            <= cnt_nx_s;
            in_flight_r      <= in_flight_nx_s;
            in_flight_last_r <= in_flight_last_nx_s;
            busy_r           <= busy_nx_s;
            done_r           <= done_nx_s;
        end
    end

    // Read data returns one clock after issue; an abort discards it via the flush
    fb_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .in_valid  (in_flight_r),
        .in_data   (mem_rd_data),
        .in_last   (in_flight_last_r),
        .out_valid (tx_valid),
        .out_data  (tx_data),
        .out_last  (tx_last),
        .out_ready (tx_ready),
        .occupancy (occ_s)
    );

    assign mem_addr = addr_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_framebuffer_streamer.sv
// Scoreboard bench for framebuffer_streamer: expected bytes are queued at frame
// start and popped on each stream handshake.
`timescale 1ns/1ps
module tb_framebuffer_streamer;
    import framebuffer_streamer_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int FB = FB_FRAME_BYTES;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, busy, done, tx_valid, tx_ready, tx_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data, tx_data;
    logic          start1, abort1, busy1, done1, tx_valid1, tx_ready1, tx_last1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_rd_data1, tx_data1;
`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
    logic          swap_req, disp_bank, swap_req1, disp_bank1;
`endif

    logic [DW-1:0] bram [0:(2**AW)-1];

    always @(posedge clk) begin
        mem_rd_data  <= bram[mem_addr];
        mem_rd_data1 <= bram[mem_addr1];
    end

    framebuffer_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_BYTES(FB), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last)
`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
        , .swap_req(swap_req), .disp_bank(disp_bank)
`endif
    );

    framebuffer_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_BYTES(1), .BASE_ADDR(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
        .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_last(tx_last1)
`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
        , .swap_req(swap_req1), .disp_bank(disp_bank1)
`endif
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] exp_q [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    // one clock: scoreboard/stability checks at negedge, return 1ns after posedge
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        if (tx_valid && prev_stall) begin
            tests_run++;
            if ({tx_last, tx_data} !== {prev_last, prev_data}) begin
                tests_failed++;
                $display("FAIL stall_stable: got %h required %h", {tx_last, tx_data}, {prev_last, prev_data});
            end
        end
        if (tx_valid && tx_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_byte: got %h required no byte", tx_data);
            end else begin
                e = exp_q.pop_front();
                if ({tx_last, tx_data} !== e) begin
                    tests_failed++;
                    $display("FAIL stream_byte: got last=%b data=%h required last=%b data=%h",
                             tx_last, tx_data, e[8], e[7:0]);
                end
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit inv);
        logic [7:0] b;
        for (int i = 0; i < FB; i++) begin
            b = 8'(i);
            exp_q.push_back({(i == FB - 1), (inv ? ~b : b)});
        end
    endtask

    task automatic drain(input int stop_at, input bit rnd, output int bubbles, output int left);
        int n;
        n = 0;
        bubbles = 0;
        while (exp_q.size() > stop_at && n < 6000) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!tx_valid) bubbles++;
            tick();
            n++;
        end
        left = exp_q.size() - stop_at;
        tx_ready = 1'b1;
    endtask

    task automatic begin_frame(input bit inv);
        push_frame(inv);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; tx_ready1 = 1'b0;
`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
        swap_req = 1'b0; swap_req1 = 1'b0;
`endif
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if ({busy, done, tx_valid, tx_last} !== 4'b0000 || tx_data !== 8'h00 || mem_addr !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b last=%b data=%h addr=%0d required all 0",
                     busy, done, tx_valid, tx_last, tx_data, mem_addr);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b required 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_stream_full();
        int n, bub, left;
        tx_ready = 1'b1;
        begin_frame(1'b0);
        tests_run++;
        if (busy !== 1'b1 || mem_addr !== 11'd0 || tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_accept: got busy=%b addr=%0d valid=%b required 1 0 0", busy, mem_addr, tx_valid);
        end
        n = 0;
        while (!tx_valid && n < 10) begin tick(); n++; end
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL first_valid_latency: got %0d clks required 2", n);
        end
        drain(0, 1'b0, bub, left);
        tests_run++;
        if (left !== 0 || bub !== 0) begin
            tests_failed++;
            $display("FAIL full_frame: got left=%0d bubbles=%0d required 0 0", left, bub);
        end
        tests_run++;
        if (done !== 1'b1 || tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse: got done=%b valid=%b required 1 0", done, tx_valid);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_end: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_random_ready();
        int bub, left;
        begin_frame(1'b0);
        drain(0, 1'b1, bub, left);
        tests_run++;
        if (left !== 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL random_ready_frame: got left=%0d done=%b required 0 1", left, done);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_ready_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_stall();
        int n, max_adv, bub, left;
        tx_ready = 1'b0;
        begin_frame(1'b0);
        n = 0;
        while (!tx_valid && n < 10) begin tick(); n++; end
        max_adv = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            if (int'(mem_addr) > max_adv) max_adv = int'(mem_addr);
            tick();
        end
        start = 1'b0;
        tests_run++;
        if (max_adv > 2 || busy !== 1'b1 || tx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_prefetch: got adv=%0d busy=%b valid=%b required adv<=2 1 1", max_adv, busy, tx_valid);
        end
        drain(0, 1'b0, bub, left);
        tests_run++;
        if (left !== 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_resume: got left=%0d done=%b required 0 1", left, done);
        end
        tick();
    endtask

    task automatic test_abort();
        int bub, left, dones;
        begin_frame(1'b0);
        drain(FB - 500, 1'b0, bub, left);
        tx_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_drop: got valid=%b busy=%b required 0 0", tx_valid, busy);
        end
        dones = 0;
        for (int i = 0; i < 5; i++) begin if (done) dones++; tick(); end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d done cycles required 0", dones);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_abort_idle: got busy=%b valid=%b required 0 0", busy, tx_valid);
        end
        exp_q.delete();
        tx_ready = 1'b1;
        begin_frame(1'b0);
        drain(0, 1'b0, bub, left);
        tests_run++;
        if (left !== 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_after_abort: got left=%0d done=%b required 0 1", left, done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int bub, left;
        begin_frame(1'b0);
        drain(FB - 300, 1'b0, bub, left);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, tx_valid, tx_last} !== 4'b0000 || tx_data !== 8'h00 || mem_addr !== 11'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b last=%b data=%h addr=%0d required all 0",
                     busy, done, tx_valid, tx_last, tx_data, mem_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        prev_stall = 1'b0;
        tick();
        begin_frame(1'b0);
        drain(0, 1'b0, bub, left);
        tests_run++;
        if (left !== 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL replay_after_reset: got left=%0d done=%b required 0 1", left, done);
        end
        tick();
    endtask

`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        int bub, left;
        tests_run++;
        if (disp_bank !== 1'b0) begin
            tests_failed++;
            $display("FAIL bank_initial: got %b required 0", disp_bank);
        end
        begin_frame(1'b0);
        drain(FB - 100, 1'b0, bub, left);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tests_run++;
        if (disp_bank !== 1'b0) begin
            tests_failed++;
            $display("FAIL bank_midframe: got %b required 0", disp_bank);
        end
        drain(0, 1'b0, bub, left);
        tick();
        begin_frame(1'b1);
        tests_run++;
        if (disp_bank !== 1'b1 || mem_addr !== 11'd1024) begin
            tests_failed++;
            $display("FAIL bank_swap: got bank=%b addr=%0d required 1 1024", disp_bank, mem_addr);
        end
        drain(0, 1'b0, bub, left);
        tests_run++;
        if (left !== 0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL bank1_frame: got left=%0d done=%b required 0 1", left, done);
        end
        tick();
    endtask
`endif

    task automatic test_single_byte();
        int n;
        tx_ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        tests_run++;
        if (busy1 !== 1'b1 || mem_addr1 !== 11'd5) begin
            tests_failed++;
            $display("FAIL single_accept: got busy=%b addr=%0d required 1 5", busy1, mem_addr1);
        end
        n = 0;
        while (!tx_valid1 && n < 10) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (n !== 2 || tx_data1 !== 8'h05 || tx_last1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_byte: got lat=%0d data=%h last=%b required 2 05 1", n, tx_data1, tx_last1);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done1 !== 1'b1 || tx_valid1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got done=%b valid=%b required 1 0", done1, tx_valid1);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: got done=%b busy=%b required 0 0", done1, busy1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) bram[i] = (i < FB) ? 8'(i) : ~8'(i - FB);
        test_reset();
        test_stream_full();
        test_random_ready();
        test_stall();
        test_abort();
        test_async_reset();
`ifdef FB_STREAMER_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        test_single_byte();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
